// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: control codes from the
// ID-stage controller, the per-cycle fetch action and the IF/ID payload.
package fetch_unit_pkg;

  // Canonical RV32I NOP (addi x0, x0, 0) inserted into bubbles.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // pc_sel codes; 2'b11 behaves exactly like PC_PLUS4.
  typedef enum logic [1:0] {
    PC_PLUS4     = 2'b00,
    PC_JUMP      = 2'b01,
    PC_HOLD      = 2'b10,
    PC_ALT_PLUS4 = 2'b11
  } pc_sel_e;

  // instr_sel codes; every value other than INSTR_FLUSH is a normal cycle.
  typedef enum logic [1:0] {
    INSTR_NORMAL = 2'b00,
    INSTR_FLUSH  = 2'b10
  } instr_sel_e;

  // What the stage does this cycle, after priority resolution.
  typedef enum logic [2:0] {
    ACT_ADVANCE  = 3'd0,
    ACT_HOLD     = 3'd1,
    ACT_STALL    = 3'd2,
    ACT_FLUSH    = 3'd3,
    ACT_REDIRECT = 3'd4
  } fetch_act_e;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{pc: 32'h0000_0000, instr: NOP, valid: 1'b0};

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture buffer for the instruction SRAM read data. The SRAM only
// presents a response for one cycle, so when the stage stalls the response is
// parked here until the stall releases.
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic        i_consume,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_valid;

  // Capture once per stall, drop on consume, and drop unconditionally on clear.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // NOTE: the data word is reset to NOP even though r_valid alone guards its
  // use, so a stale instruction can never leak out after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= NOP;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture && !r_valid) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory (one-cycle read latency) and feeds the IF/ID register. Handles
// redirect, flush, load-use stall and controller hold, in that priority.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_AW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      jump_addr,
  input  logic [1:0]       instr_sel,
  input  logic             stall,
  output logic             im_en,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc_id,
  output logic [31:0]      instr_id,
  output logic             id_valid,
  output logic             misalign_pulse
);

  // PC currently presented to the SRAM, and the PC whose data returns now.
  logic [31:0] r_pc_if;
  logic [31:0] r_pc_req;
  logic        r_req_valid;
  ifid_t       r_ifid;
  logic        r_misalign;

  fetch_act_e  w_act;
  logic [31:0] w_pc_next;
  logic [31:0] w_buf_data;
  logic        w_buf_valid;
  logic [31:0] w_resp;
  ifid_t       w_ifid_load;
  logic        w_capture;
  logic        w_consume;
  logic        w_clear;

  assign im_en   = ~rst;
  assign im_addr = r_pc_if[IM_AW+1:2];

  // Resolve the cycle's action: redirect > flush > stall > hold > advance.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_act = ACT_ADVANCE;
    if (pc_sel == PC_JUMP) begin
      w_act = ACT_REDIRECT;
    end else if (instr_sel == INSTR_FLUSH) begin
      w_act = ACT_FLUSH;
    end else if (stall) begin
      w_act = ACT_STALL;
    end else if (pc_sel == PC_HOLD) begin
      w_act = ACT_HOLD;
    end
  end

  // Next fetch address; a flush still honours the controller's PC choice.
  always_comb begin
    w_pc_next = r_pc_if;
    unique case (w_act)
      ACT_REDIRECT: w_pc_next = word_align(jump_addr);
      ACT_FLUSH:    if (pc_sel != PC_HOLD) w_pc_next = pc_plus4(r_pc_if);
      ACT_ADVANCE:  w_pc_next = pc_plus4(r_pc_if);
      default:      w_pc_next = r_pc_if;
    endcase
  end

  // The buffer parks the response at the start of a stall; squashing actions
  // discard it and any cycle that moves IF/ID forward consumes it.
  assign w_capture = (w_act == ACT_STALL) && r_req_valid;
  assign w_consume = (w_act == ACT_ADVANCE) || (w_act == ACT_HOLD);
  assign w_clear   = (w_act == ACT_REDIRECT) || (w_act == ACT_FLUSH);

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .i_capture(w_capture),
    .i_consume(w_consume),
    .i_clear  (w_clear),
    .i_data   (im_rdata),
    .o_data   (w_buf_data),
    .o_valid  (w_buf_valid)
  );

  // After a stall the parked word belongs to r_pc_req; the live SRAM output
  // has already moved on to r_pc_if, which the SRAM re-read during the stall.
  assign w_resp = w_buf_valid ? w_buf_data : im_rdata;

  // Value the IF/ID register takes when the pipe moves forward.
  always_comb begin
    w_ifid_load = IFID_RESET;
    if (r_req_valid) begin
      w_ifid_load = '{pc: r_pc_req, instr: w_resp, valid: 1'b1};
    end else begin
      w_ifid_load = '{pc: r_pc_req, instr: NOP, valid: 1'b0};
    end
  end

  // PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_if     <= RESET_PC;
      r_pc_req    <= RESET_PC;
      r_req_valid <= 1'b0;
    end else begin
      r_pc_if <= w_pc_next;
      unique case (w_act)
        ACT_ADVANCE: begin
          r_pc_req    <= r_pc_if;
          r_req_valid <= 1'b1;
        end
        ACT_STALL: begin
          r_pc_req    <= r_pc_req;
          r_req_valid <= r_req_valid;
        end
        default: begin
          // Redirect, flush and hold all leave no live request behind.
          r_pc_req    <= r_pc_if;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: bubbles on squash, frozen on stall, loads otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid <= IFID_RESET;
    end else begin
      unique case (w_act)
        ACT_REDIRECT, ACT_FLUSH: r_ifid <= '{pc: r_ifid.pc, instr: NOP, valid: 1'b0};
        ACT_HOLD, ACT_ADVANCE:   r_ifid <= w_ifid_load;
        default:                 r_ifid <= r_ifid;
      endcase
    end
  end

  // Single-cycle flag for a redirect target with bit 1 set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (w_act == ACT_REDIRECT) && jump_addr[1];
    end
  end

  assign pc_id          = r_ifid.pc;
  assign instr_id       = r_ifid.instr;
  assign id_valid       = r_ifid.valid;
  assign misalign_pulse = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// control traffic, compared each cycle against a transaction-level model of
// the fetch stream (next fetch PC, one in-flight request, ID slot).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          IM_AW    = 14;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       pc_sel;
  logic [31:0]      jump_addr;
  logic [1:0]       instr_sel;
  logic             stall;
  logic             im_en;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      pc_id;
  logic [31:0]      instr_id;
  logic             id_valid;
  logic             misalign_pulse;

  fetch_unit #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .jump_addr     (jump_addr),
    .instr_sel     (instr_sel),
    .stall         (stall),
    .im_en         (im_en),
    .im_addr       (im_addr),
    .im_rdata      (im_rdata),
    .pc_id         (pc_id),
    .instr_id      (instr_id),
    .id_valid      (id_valid),
    .misalign_pulse(misalign_pulse)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with one-cycle read latency.
  logic [31:0] mem [0:(1<<IM_AW)-1];
  always @(posedge clk) if (im_en) im_rdata <= mem[im_addr];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_fpc;
  logic        m_inf_v;
  logic [31:0] m_inf_pc;
  logic        m_id_v;
  logic [31:0] m_id_pc;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] im_word(input logic [31:0] pc);
    return mem[pc[IM_AW+1:2]];
  endfunction

  // Abstract stream model: ID shows whatever request was in flight, the
  // instruction is simply the memory word at that PC.
  task automatic model_step();
    m_mis = 1'b0;
    if (rst) begin
      m_fpc   = RESET_PC;
      m_inf_v = 1'b0;
      m_id_v  = 1'b0;
      m_id_pc = 32'h0;
    end else if (pc_sel == 2'b01) begin
      m_id_v  = 1'b0;
      m_inf_v = 1'b0;
      m_mis   = jump_addr[1];
      m_fpc   = {jump_addr[31:2], 2'b00};
    end else if (instr_sel == 2'b10) begin
      m_id_v  = 1'b0;
      m_inf_v = 1'b0;
      if (pc_sel != 2'b10) m_fpc = m_fpc + 32'd4;
    end else if (stall) begin
      m_id_v = m_id_v;
    end else begin
      m_id_v  = m_inf_v;
      m_id_pc = m_inf_pc;
      if (pc_sel == 2'b10) begin
        m_inf_v = 1'b0;
      end else begin
        m_inf_v  = 1'b1;
        m_inf_pc = m_fpc;
        m_fpc    = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic drive(input logic [1:0] ps, input logic [31:0] ja,
                       input logic [1:0] is, input logic st);
    pc_sel    = ps;
    jump_addr = ja;
    instr_sel = is;
    stall     = st;
  endtask

  // One clock: advance the model at the edge, compare 1 time unit later.
  task automatic tick();
    logic [31:0] exp_instr;
    @(posedge clk);
    model_step();
    #1;
    exp_instr = m_id_v ? im_word(m_id_pc) : NOP_W;
    check("im_en",    32'(im_en),          32'(!rst));
    check("im_addr",  32'(im_addr),        32'(m_fpc[IM_AW+1:2]));
    check("id_valid", 32'(id_valid),       32'(m_id_v));
    check("instr_id", instr_id,            exp_instr);
    if (m_id_v) check("pc_id", pc_id, m_id_pc);
    check("misalign", 32'(misalign_pulse), 32'(m_mis));
  endtask

  initial begin
    for (int k = 0; k < (1 << IM_AW); k++) mem[k] = 32'h0000_1000 + 32'(k);
    rst = 1'b1;
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    check("rst_pc_id",    pc_id,                32'h0);
    check("rst_instr_id", instr_id,             NOP_W);
    check("rst_id_valid", 32'(id_valid),        32'h0);
    check("rst_misalign", 32'(misalign_pulse),  32'h0);
    check("rst_im_en",    32'(im_en),           32'h0);
    check("rst_im_addr",  32'(im_addr),         32'h40);

    // Start-up latency and sequential stream.
    rst = 1'b0;
    tick();
    check("start_addr1", 32'(im_addr),  32'h41);
    check("start_bubble", 32'(id_valid), 32'h0);
    tick();
    check("first_valid", 32'(id_valid), 32'h1);
    check("first_pc",    pc_id,         32'h100);
    check("first_instr", instr_id,      32'h1040);
    tick();
    check("seq_pc104", pc_id, 32'h104);
    tick();
    check("seq_pc108", pc_id, 32'h108);

    // Redirect: two bubbles, then the target.
    drive(2'b01, 32'h200, 2'b00, 1'b0);
    tick();
    check("redir_bub1", 32'(id_valid), 32'h0);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    check("redir_bub2", 32'(id_valid), 32'h0);
    tick();
    check("redir_pc",    pc_id,    32'h200);
    check("redir_instr", instr_id, 32'h1080);

    // Stall three cycles while pc_req = 0x110.
    drive(2'b01, 32'h10C, 2'b00, 1'b0);
    tick();
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    check("pre_stall_pc", pc_id, 32'h10C);
    drive(2'b00, 32'h0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc",    pc_id,         32'h10C);
      check("stall_hold_valid", 32'(id_valid), 32'h1);
    end
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    check("release_pc",    pc_id,    32'h110);
    check("release_instr", instr_id, 32'h1044);
    tick();
    check("after_rel_pc",    pc_id,    32'h114);
    check("after_rel_instr", instr_id, 32'h1045);

    // Redirect and stall together, with the capture buffer occupied.
    drive(2'b00, 32'h0, 2'b00, 1'b1);
    tick();
    drive(2'b01, 32'h300, 2'b00, 1'b1);
    tick();
    check("rs_bub1", 32'(id_valid), 32'h0);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    check("rs_bub2", 32'(id_valid), 32'h0);
    tick();
    check("rs_pc",    pc_id,    32'h300);
    check("rs_instr", instr_id, 32'h10C0);

    // Misaligned redirect target.
    drive(2'b01, 32'h20E, 2'b00, 1'b0);
    tick();
    check("mis_addr",  32'(im_addr),        32'h83);
    check("mis_pulse", 32'(misalign_pulse), 32'h1);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    check("mis_drop", 32'(misalign_pulse), 32'h0);
    tick();
    check("mis_pc",    pc_id,    32'h20C);
    check("mis_instr", instr_id, 32'h1083);

    // Reset while the capture buffer holds a word.
    drive(2'b00, 32'h0, 2'b00, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(id_valid), 32'h0);
    check("mrst_instr", instr_id,      NOP_W);
    check("mrst_addr",  32'(im_addr),  32'h40);
    rst = 1'b0;
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    check("mrst_pc",     pc_id,    32'h100);
    check("mrst_instr2", instr_id, 32'h1040);

    // Random control traffic.
    for (int c = 0; c < 3000; c++) begin
      int          r;
      logic [1:0]  ps;
      logic [1:0]  is;
      logic [31:0] ja;
      r = int'($urandom_range(0, 99));
      if (r < 70)      ps = 2'b00;
      else if (r < 80) ps = 2'b11;
      else if (r < 90) ps = 2'b10;
      else             ps = 2'b01;
      if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           ja = $urandom;
      if ($urandom_range(0, 99) < 8) is = 2'b10;
      else begin
        is = 2'($urandom_range(0, 2));
        if (is == 2'b10) is = 2'b11;
      end
      drive(ps, ja, is, ($urandom_range(0, 99) < 20));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
